// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encodings and constants for the external memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_STATE_CPU     = 3'd0,
    ARB_STATE_HOLD    = 3'd1,
    ARB_STATE_ACCESS  = 3'd2,
    ARB_STATE_DONE    = 3'd3,
    ARB_STATE_RELEASE = 3'd4
  } arb_state_t;

  localparam logic BUS_OWNER_CPU = 1'b0;
  localparam logic BUS_OWNER_DMA = 1'b1;

  localparam int WAIT_W  = 4;
  localparam int BURST_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_dma_byte_lane.sv
// DMA-side lane steering: write data placement, strobe decode and read zero-extension.
module mem_bus_arbiter_dma_byte_lane (
  input  logic        strobe_en,
  input  logic        addr_odd,
  input  logic [15:0] dma_dout,
  input  logic        dma_wr,
  input  logic        dma_byte,
  input  logic [15:0] mem_din,
  output logic [15:0] mem_dout,
  output logic        mem_rdn,
  output logic        mem_wrn0,
  output logic        mem_wrn1,
  output logic [15:0] rd_data
);

  // Byte data always arrives in [7:0]; an odd byte lands on the high lane.
  assign mem_dout = (dma_byte && addr_odd) ? {dma_dout[7:0], 8'h00} : dma_dout;

  assign mem_rdn  = ~strobe_en | dma_wr;
  assign mem_wrn0 = ~strobe_en | ~dma_wr | (dma_byte &  addr_odd);
  assign mem_wrn1 = ~strobe_en | ~dma_wr | (dma_byte & ~addr_odd);

  assign rd_data = !dma_byte ? mem_din :
                   addr_odd  ? {8'h00, mem_din[15:8]} : {8'h00, mem_din[7:0]};

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between the CPU bus controller and a secondary master,
// admitting the secondary only at core safe points and for a bounded burst.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BURST_MAX   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_DOUT,
  input  logic        CPU_RDN,
  input  logic        CPU_WRN0,
  input  logic        CPU_WRN1,
  input  logic        CPU_SAFE,
  output logic        CPU_HOLD,
  input  logic        DMA_REQ,
  input  logic [15:0] DMA_ADDR,
  input  logic [15:0] DMA_DOUT,
  input  logic        DMA_WR,
  input  logic        DMA_BYTE,
  output logic        DMA_ACK,
  output logic [15:0] DMA_DIN,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  input  logic [15:0] MEM_DIN,
  output logic        MEM_RDN,
  output logic        MEM_WRN0,
  output logic        MEM_WRN1,
  output logic        BUS_OWNER
);

  arb_state_t         state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W:0]   burst_next;

  logic [15:0] lane_dout;
  logic [15:0] lane_rd_data;
  logic        lane_rdn;
  logic        lane_wrn0;
  logic        lane_wrn1;

  assign burst_next = {1'b0, burst_cnt} + 9'd1;

  mem_bus_arbiter_dma_byte_lane u_lane (
    .strobe_en (state == ARB_STATE_ACCESS),
    .addr_odd  (DMA_ADDR[0]),
    .dma_dout  (DMA_DOUT),
    .dma_wr    (DMA_WR),
    .dma_byte  (DMA_BYTE),
    .mem_din   (MEM_DIN),
    .mem_dout  (lane_dout),
    .mem_rdn   (lane_rdn),
    .mem_wrn0  (lane_wrn0),
    .mem_wrn1  (lane_wrn1),
    .rd_data   (lane_rd_data)
  );

  always_comb begin
    // NOTE: every output gets a default before the branch, so no path can infer a latch.
    MEM_ADDR = CPU_ADDR;
    MEM_DOUT = CPU_DOUT;
    MEM_RDN  = CPU_RDN;
    MEM_WRN0 = CPU_WRN0;
    MEM_WRN1 = CPU_WRN1;
    if (state != ARB_STATE_CPU) begin
      MEM_ADDR = DMA_ADDR;
      MEM_DOUT = lane_dout;
      MEM_RDN  = lane_rdn;
      MEM_WRN0 = lane_wrn0;
      MEM_WRN1 = lane_wrn1;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ARB_STATE_CPU;
      CPU_HOLD  <= 1'b0;
      DMA_ACK   <= 1'b0;
      DMA_DIN   <= 16'h0000;
      BUS_OWNER <= BUS_OWNER_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      DMA_ACK <= 1'b0;
      unique case (state)
        ARB_STATE_CPU: begin
          if (DMA_REQ && CPU_SAFE) begin
            state     <= ARB_STATE_HOLD;
            CPU_HOLD  <= 1'b1;
            BUS_OWNER <= BUS_OWNER_DMA;
          end
        end
        ARB_STATE_HOLD: begin
          burst_cnt <= '0;
          wait_cnt  <= WAIT_W'(WAIT_STATES);
          state     <= ARB_STATE_ACCESS;
        end
        ARB_STATE_ACCESS: begin
          // Once started an access always completes, even if DMA_REQ drops.
          if (wait_cnt == '0) begin
            if (!DMA_WR) DMA_DIN <= lane_rd_data;
            DMA_ACK <= 1'b1;
            state   <= ARB_STATE_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ARB_STATE_DONE: begin
          burst_cnt <= burst_cnt + 1'b1;
          if (DMA_REQ && (burst_next < 9'(BURST_MAX))) begin
            wait_cnt <= WAIT_W'(WAIT_STATES);
            state    <= ARB_STATE_ACCESS;
          end else begin
            BUS_OWNER <= BUS_OWNER_CPU;
            state     <= ARB_STATE_RELEASE;
          end
        end
        ARB_STATE_RELEASE: begin
          CPU_HOLD <= 1'b0;
          state    <= ARB_STATE_CPU;
        end
        default: state <= ARB_STATE_CPU;
      endcase
    end
  end

endmodule
